// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter.
package uart_pkg;

  // Arbiter FSM encoding: waiting for a requester, or streaming its bytes.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int gid_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker: first set request bit after last_owner, with wrap.
module rr_picker
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int GW      = gid_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_owner,
  output logic [GW-1:0]      winner,
  output logic               any
);

  logic [GW-1:0] idx;

  // Walk the requesters starting one past the previous owner; keep the first hit.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_owner) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte streams from several requesters into one TX FIFO write port.
//
// Handshake: a requester byte moves when req_valid[i] & req_ready[i] are both
// high at a rising PCLK edge; that same cycle tx_fifo_write_en is high with the
// byte on tx_fifo_wdata. req_ready only rises for the granted requester and
// only while the FIFO is not full, so a stalled byte stays with its requester.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 16,
  localparam int GW        = gid_width(NUM_REQ)
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 arb_en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_fifo_full,
  output logic                 tx_fifo_write_en,
  output logic [7:0]           tx_fifo_wdata,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output arb_state_e           state_dbg
);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [GW-1:0] pick_winner;
  logic          pick_any;
  logic          accept;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req_valid),
    .last_owner (last_q),
    .winner     (pick_winner),
    .any        (pick_any)
  );

  // Datapath and handshake: only the owner sees ready, gated by FIFO space.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (state_q == ST_XFER) begin
      req_ready[grant_q] = !tx_fifo_full;
      accept             = req_valid[grant_q] & !tx_fifo_full;
    end
    tx_fifo_write_en = accept;
    tx_fifo_wdata    = req_data[8*int'(grant_q) +: 8];
  end

  // Next state: grant on arbitration, release on last byte or burst limit.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && pick_any) begin
          state_d = ST_XFER;
          grant_d = pick_winner;
          cnt_d   = '0;
        end
      end
      ST_XFER: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          if (req_last[grant_q] || (cnt_q == 8'(MAX_BURST - 1))) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset restarts priority at requester 0.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == ST_XFER);
  assign grant_id  = grant_q;
  assign state_dbg = state_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of byte-stream requesters, range 2..8.
REQ-002 SHALL have parameter MAX_BURST, default 16: maximum bytes per grant before forced re-arbitration, range 1..255.
REQ-003 SHALL have one clock and an asynchronous active-low reset: PCLK input 1, rising-edge clock; PRESETn input 1, asynchronous active-low reset.
REQ-004 SHALL have arb_en input 1: arbitration enable; new grants are issued only while high.
REQ-005 SHALL have req_valid input NUM_REQ: byte available, one bit per requester.
REQ-006 SHALL have req_data input NUM_REQ*8: byte of requester i at bits [8i+7:8i].
REQ-007 SHALL have req_last input NUM_REQ: marks the final byte of a message.
REQ-008 SHALL have req_ready output NUM_REQ: byte accepted this cycle when ANDed with req_valid.
REQ-009 SHALL have tx_fifo_full input 1: TX FIFO cannot accept a write.
REQ-010 SHALL have tx_fifo_write_en output 1: TX FIFO write strobe.
REQ-011 SHALL have tx_fifo_wdata output 8: byte to the TX FIFO.
REQ-012 SHALL have grant_id output clog2(NUM_REQ): index of the current owner, valid while busy.
REQ-013 SHALL have busy output 1: high in XFER.

Function
REQ-014 SHALL implement FSM states IDLE and XFER only.
REQ-015 In IDLE with arb_en=1 and any req_valid bit set, SHALL register the winner into grant_id and enter XFER on the next edge, giving 1-cycle arbitration latency.
REQ-016 Winner SHALL be the first set req_valid bit searching from (last_owner+1) mod NUM_REQ upward with wrap-around; last_owner resets to NUM_REQ-1, so requester 0 has first priority after reset.
REQ-017 In XFER, req_ready[grant_id] SHALL equal !tx_fifo_full, and all other req_ready bits SHALL be 0; req_ready SHALL be all-zero in IDLE.
REQ-018 tx_fifo_write_en SHALL equal req_valid[grant_id] & req_ready[grant_id], combinationally, and tx_fifo_wdata SHALL equal req_data slice grant_id.
REQ-019 An 8-bit burst counter SHALL clear on entry to XFER and increment on each accepted byte.
REQ-020 On an accepted byte with req_last=1, or with count=MAX_BURST-1, SHALL return to IDLE, set last_owner to grant_id, and drop the grant.
REQ-021 Owner deasserting req_valid mid-message SHALL hold XFER and the grant indefinitely; there is no timeout.
REQ-022 tx_fifo_full=1 SHALL stall the transfer without advancing the counter; the byte is held by the requester.
REQ-023 arb_en falling during XFER SHALL NOT abort; the current grant completes per REQ-020, then the FSM stays in IDLE.
REQ-024 A requester asserting req_valid while another owns the grant SHALL wait; it is never starved, because the maximum wait is (NUM_REQ-1)*MAX_BURST accepted bytes.
REQ-025 Returning to IDLE SHALL cost 1 idle cycle, so back-to-back grants are separated by exactly one cycle with req_ready all-zero.

Reset
REQ-026 PRESETn low SHALL asynchronously force state IDLE, grant_id 0, burst counter 0, last_owner NUM_REQ-1, busy 0, req_ready 0, and tx_fifo_write_en 0.
REQ-027 Reset asserted mid-XFER SHALL discard the grant; any partially sent message is not resumed after reset.

Structure
REQ-028 The state encoding and the grant-id width function SHALL reside in shared package uart_pkg.
REQ-029 The rotating-priority search SHALL be a combinational sub-module rr_picker, parameterised by NUM_REQ, with inputs req and last_owner and outputs winner and any.

Verification
REQ-030 Reset release, arb_en=1, req_valid=4'b0001 sending 3 bytes 0x41,0x42,0x43 with last on 0x43 -> busy rises the cycle after valid, 3 consecutive writes with matching data, then IDLE.
REQ-031 All four requesters valid, each sending 2-byte messages -> grant order 0,1,2,3,0 with exactly one idle cycle between grants.
REQ-032 MAX_BURST=4, requester 2 streams 10 bytes with no last and requester 3 also valid -> grant switches to 3 after the 4th byte of requester 2, and requester 2 resumes after 3's message.
REQ-033 tx_fifo_full held high for 5 cycles mid-message -> tx_fifo_write_en stays 0 and req_ready stays 0 during the stall, no byte is lost or duplicated, and the counter is unchanged.
REQ-034 arb_en dropped after the 1st byte of a 3-byte message -> the remaining 2 bytes are sent, the FSM enters IDLE, and no new grant is issued while other req_valid bits are high.
REQ-035 PRESETn pulsed low during XFER after 2 of 5 bytes -> outputs are zero immediately, and after release arbitration restarts from requester 0.
